// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and shifts
// them out one bit per enabled clock, with a one-word holding register for gapless streams.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             enable,
  output logic             x_out,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned     CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    bit_cnt;
  logic             hold_v;

  logic active;
  logic accept;
  logic last_bit;
  logic cur_bit;

  // Every output is decoded from flops plus enable only; nothing depends on in_data/in_valid.
  assign active    = (state == SHIFT);
  assign in_ready  = !hold_v;
  assign accept    = in_valid && in_ready;
  assign cur_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign x_out     = active ? cur_bit : IDLE_BIT;
  assign x_valid   = active && enable;
  assign last_bit  = (bit_cnt == LAST);
  assign word_done = x_valid && last_bit;
  assign busy      = active || hold_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      hold    <= '0;
      bit_cnt <= '0;
      hold_v  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= in_data;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable && last_bit) begin
            // Next word priority: holding register, then a word arriving right now, else idle.
            if (hold_v) begin
              shreg   <= hold;
              bit_cnt <= '0;
              hold_v  <= accept;
              if (accept) hold <= in_data;
            end else if (accept) begin
              shreg   <= in_data;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= '0;
              state   <= IDLE;
            end
          end else begin
            if (enable) begin
              shreg   <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (accept) begin
              hold   <= in_data;
              hold_v <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
